// File: rtl/dds_cordic_multichannel.sv
// Time-multiplexed multi-channel DDS: per-channel phase accumulators feed one
// pipelined CORDIC rotator round-robin; each sin/cos pair carries its channel tag.
module dds_cordic_multichannel #(
   parameter int PHASE_WIDTH   = 16,
   parameter int VALUE_WIDTH   = 12,
   parameter int CHANNELS      = 4,
   parameter int CORDIC_STAGES = 12,
   parameter int INITIAL_STEP  = 1,
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          enable,
   input  logic                          SET,
   input  logic                          set_sel,
   input  logic [CH_W-1:0]               set_channel,
   input  logic [PHASE_WIDTH-1:0]        set_data,
   output logic signed [VALUE_WIDTH-1:0] sin_value,
   output logic signed [VALUE_WIDTH-1:0] cos_value,
   output logic                          value_valid,
   output logic [CH_W-1:0]               value_channel,
   output logic                          zero_phase
);

   // Datapath keeps VALUE_WIDTH+2 integer bits plus GUARD fraction bits; angles
   // carry ZF fraction bits below the phase LSB (full circle = 2^ZW).
   localparam int S     = CORDIC_STAGES;
   localparam int GUARD = 6;
   localparam int ZF    = 4;
   localparam int DW    = VALUE_WIDTH + 2 + GUARD;
   localparam int ZW    = PHASE_WIDTH + ZF;
   localparam int AMP   = (1 << (VALUE_WIDTH - 1)) - 1;
   localparam longint X0_INT = (longint'(607253) * AMP + 500000) / 1000000;
   localparam logic signed [DW-1:0] X0     = DW'(X0_INT << GUARD);
   localparam logic signed [DW-1:0] HALF   = DW'(1 << (GUARD - 1));
   localparam logic signed [DW-1:0] SAT_HI = DW'(AMP);
   localparam logic signed [DW-1:0] SAT_LO = -SAT_HI;

   // atan(2^-i) scaled to 2^32 per full circle, rescaled to 2^ZW per circle.
   function automatic logic signed [ZW-1:0] atan_rom(input int i);
      logic [63:0] a;
      case (i)
         0:  a = 64'h2000_0000;
         1:  a = 64'h12E4_051E;
         2:  a = 64'h09FB_385B;
         3:  a = 64'h0511_11D4;
         4:  a = 64'h028B_0D43;
         5:  a = 64'h0145_D7E1;
         6:  a = 64'h00A2_F61E;
         7:  a = 64'h0051_7C55;
         8:  a = 64'h0028_BE53;
         9:  a = 64'h0014_5F2F;
         10: a = 64'h000A_2F98;
         11: a = 64'h0005_17CC;
         12: a = 64'h0002_8BE6;
         13: a = 64'h0001_45F3;
         14: a = 64'h0000_A2FA;
         15: a = 64'h0000_517D;
         16: a = 64'h0000_28BE;
         17: a = 64'h0000_145F;
         default: a = 64'h0;
      endcase
      if (ZW < 32) a = (a + (64'd1 << (31 - ZW))) >> (32 - ZW);
      else         a = a << (ZW - 32);
      return ZW'(a);
   endfunction

   function automatic logic signed [VALUE_WIDTH-1:0] sat_round(input logic signed [DW-1:0] v);
      logic signed [DW-1:0] r;
      r = (v + HALF) >>> GUARD;
      if (r > SAT_HI)      r = SAT_HI;
      else if (r < SAT_LO) r = SAT_LO;
      return r[VALUE_WIDTH-1:0];
   endfunction

   logic [PHASE_WIDTH-1:0] acc    [CHANNELS];
   logic [PHASE_WIDTH-1:0] step   [CHANNELS];
   logic [PHASE_WIDTH-1:0] offset [CHANNELS];
   logic [CH_W-1:0]        slot;
   logic                   set_hit;
   logic [PHASE_WIDTH-1:0] issue_phase;

   assign set_hit     = SET && ({1'b0, set_channel} < (CH_W + 1)'(CHANNELS));
   assign issue_phase = acc[slot] + offset[slot];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         slot <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            acc[c]    <= '0;
            step[c]   <= PHASE_WIDTH'(INITIAL_STEP);
            offset[c] <= '0;
         end
      end else begin
         if (enable) begin
            acc[slot] <= acc[slot] + step[slot];
            slot      <= (slot == CH_W'(CHANNELS - 1)) ? '0 : slot + 1'b1;
         end
         // NOTE: the config write comes after the accumulate, so its non-blocking
         // update wins when both target the same channel in one cycle.
         if (set_hit) begin
            if (set_sel) begin
               offset[set_channel] <= set_data;
            end else begin
               step[set_channel] <= set_data;
               acc[set_channel]  <= '0;
            end
         end
      end
   end

   // vld[0] = issue, vld[1] = fold, vld[2..S+1] = CORDIC stages, vld[S+2] = round.
   logic [S+2:0] vld;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) vld <= '0;
      else        vld <= {vld[S+1:0], enable};
   end

   logic [PHASE_WIDTH-1:0]  is_phase;
   logic [CH_W-1:0]         is_ch;
   logic signed [DW-1:0]    cx  [S+1];
   logic signed [DW-1:0]    cy  [S+1];
   logic signed [ZW-1:0]    cz  [S+1];
   logic [1:0]              cq  [S+1];
   logic [CH_W-1:0]         cch [S+1];
   logic                    czr [S+1];
   logic signed [VALUE_WIDTH-1:0] rs, rc;
   logic [1:0]              rq;
   logic [CH_W-1:0]         rch;
   logic                    rz;

   // NOTE: datapath registers carry no reset; the valid bits alone decide
   // which of their contents ever reach the outputs.
   always_ff @(posedge CLK) begin
      is_phase <= issue_phase;
      is_ch    <= slot;
      cx[0]    <= X0;
      cy[0]    <= '0;
      cz[0]    <= {2'b00, is_phase[PHASE_WIDTH-3:0], {ZF{1'b0}}};
      cq[0]    <= is_phase[PHASE_WIDTH-1 -: 2];
      cch[0]   <= is_ch;
      czr[0]   <= (is_phase == '0);
      for (int i = 0; i < S; i++) begin
         if (!cz[i][ZW-1]) begin
            cx[i+1] <= cx[i] - (cy[i] >>> i);
            cy[i+1] <= cy[i] + (cx[i] >>> i);
            cz[i+1] <= cz[i] - atan_rom(i);
         end else begin
            cx[i+1] <= cx[i] + (cy[i] >>> i);
            cy[i+1] <= cy[i] - (cx[i] >>> i);
            cz[i+1] <= cz[i] + atan_rom(i);
         end
         cq[i+1]  <= cq[i];
         cch[i+1] <= cch[i];
         czr[i+1] <= czr[i];
      end
      rs  <= sat_round(cy[S]);
      rc  <= sat_round(cx[S]);
      rq  <= cq[S];
      rch <= cch[S];
      rz  <= czr[S];
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sin_value     <= '0;
         cos_value     <= '0;
         value_valid   <= 1'b0;
         value_channel <= '0;
         zero_phase    <= 1'b0;
      end else begin
         value_valid <= vld[S+2];
         if (vld[S+2]) begin
            value_channel <= rch;
            zero_phase    <= rz;
            case (rq)
               2'd0: begin sin_value <= rs;  cos_value <= rc;  end
               2'd1: begin sin_value <= rc;  cos_value <= -rs; end
               2'd2: begin sin_value <= -rs; cos_value <= -rc; end
               2'd3: begin sin_value <= -rc; cos_value <= rs;  end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dds_cordic_multichannel.sv
// Self-checking bench: a 4-channel and a 3-channel DDS share one random/directed
// stimulus stream and are scored against an arithmetic phase/sine model.
module tb_dds_cordic_multichannel;

   localparam int PW     = 16;
   localparam int VW     = 12;
   localparam int STAGES = 12;
   localparam int LAT    = STAGES + 3;
   localparam int AMP    = 2047;
   localparam int HIST   = 64;
   localparam real TWO_PI = 6.283185307179586;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        enable = 1'b1;
   logic        SET = 1'b0;
   logic        set_sel = 1'b0;
   logic [1:0]  set_channel = '0;
   logic [15:0] set_data = '0;

   logic signed [VW-1:0] sin_v [2];
   logic signed [VW-1:0] cos_v [2];
   logic                 vv    [2];
   logic [1:0]           vch   [2];
   logic                 zp    [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   dds_cordic_multichannel #(.PHASE_WIDTH(PW), .VALUE_WIDTH(VW), .CHANNELS(4),
                             .CORDIC_STAGES(STAGES), .INITIAL_STEP(1)) u_dut4 (
      .CLK(CLK), .RESET(RESET), .enable(enable), .SET(SET), .set_sel(set_sel),
      .set_channel(set_channel), .set_data(set_data),
      .sin_value(sin_v[0]), .cos_value(cos_v[0]), .value_valid(vv[0]),
      .value_channel(vch[0]), .zero_phase(zp[0]));

   dds_cordic_multichannel #(.PHASE_WIDTH(PW), .VALUE_WIDTH(VW), .CHANNELS(3),
                             .CORDIC_STAGES(STAGES), .INITIAL_STEP(1)) u_dut3 (
      .CLK(CLK), .RESET(RESET), .enable(enable), .SET(SET), .set_sel(set_sel),
      .set_channel(set_channel), .set_data(set_data),
      .sin_value(sin_v[1]), .cos_value(cos_v[1]), .value_valid(vv[1]),
      .value_channel(vch[1]), .zero_phase(zp[1]));

   task automatic check(input string tag, input int got, input int exp, input int tol);
      n_checks++;
      if (got > exp + tol || got < exp - tol) begin
         n_errors++;
         $display("FAIL %s got=%0d expected=%0d tol=%0d t=%0t", tag, got, exp, tol, $time);
      end
   endtask

   function automatic int nch(input int d);
      return (d == 0) ? 4 : 3;
   endfunction

   function automatic int round_r(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
   endfunction

   // Reference model: channel state plus a history of what was issued each cycle.
   int cyc = 0;
   int acc [2][4];
   int stp [2][4];
   int ofs [2][4];
   int slot [2];
   bit h_vld [2][HIST];
   int h_ch  [2][HIST];
   int h_ph  [2][HIST];

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int d = 0; d < 2; d++) begin
            slot[d] = 0;
            for (int c = 0; c < 4; c++) begin
               acc[d][c] = 0;
               stp[d][c] = 1;
               ofs[d][c] = 0;
            end
            for (int k = 0; k < HIST; k++) h_vld[d][k] = 1'b0;
         end
      end else begin
         cyc++;
         for (int d = 0; d < 2; d++) begin
            int k;
            int c;
            k = cyc % HIST;
            h_vld[d][k] = enable;
            if (enable) begin
               c = slot[d];
               h_ch[d][k] = c;
               h_ph[d][k] = (acc[d][c] + ofs[d][c]) % 65536;
               acc[d][c]  = (acc[d][c] + stp[d][c]) % 65536;
               slot[d]    = (c + 1) % nch(d);
            end
            if (SET && int'(set_channel) < nch(d)) begin
               if (set_sel) begin
                  ofs[d][set_channel] = int'(set_data);
               end else begin
                  stp[d][set_channel] = int'(set_data);
                  acc[d][set_channel] = 0;
               end
            end
         end
      end
   end

   always @(negedge CLK) begin
      for (int d = 0; d < 2; d++) begin
         int k;
         int ph;
         real ang;
         k = (cyc + HIST - LAT) % HIST;
         if (!RESET) begin
            check($sformatf("d%0d_rst_valid", d), int'(vv[d]), 0, 0);
            check($sformatf("d%0d_rst_sin", d), int'(sin_v[d]), 0, 0);
            check($sformatf("d%0d_rst_cos", d), int'(cos_v[d]), 0, 0);
            check($sformatf("d%0d_rst_chan", d), int'(vch[d]), 0, 0);
            check($sformatf("d%0d_rst_zero", d), int'(zp[d]), 0, 0);
         end else if (h_vld[d][k]) begin
            ph  = h_ph[d][k];
            ang = TWO_PI * real'(ph) / 65536.0;
            check($sformatf("d%0d_valid", d), int'(vv[d]), 1, 0);
            check($sformatf("d%0d_chan", d), int'(vch[d]), h_ch[d][k], 0);
            check($sformatf("d%0d_sin_p%0d", d, ph), int'(sin_v[d]), round_r(AMP * $sin(ang)), 2);
            check($sformatf("d%0d_cos_p%0d", d, ph), int'(cos_v[d]), round_r(AMP * $cos(ang)), 2);
            check($sformatf("d%0d_zero_p%0d", d, ph), int'(zp[d]), (ph == 0) ? 1 : 0, 0);
         end else begin
            check($sformatf("d%0d_idle_valid", d), int'(vv[d]), 0, 0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic write_cfg(input logic sel, input logic [1:0] ch, input logic [15:0] data);
      SET = 1'b1;
      set_sel = sel;
      set_channel = ch;
      set_data = data;
      tick(1);
      SET = 1'b0;
   endtask

   initial begin
      #1 RESET = 1'b0;
      tick(5);
      @(posedge CLK);
      #2 RESET = 1'b1;
      tick(40);

      // Quadrature on ch0, then ch1 (offset 90 deg) against ch2.
      write_cfg(1'b0, 2'd0, 16'd16384);
      tick(40);
      write_cfg(1'b0, 2'd1, 16'd16384);
      write_cfg(1'b0, 2'd2, 16'd16384);
      write_cfg(1'b1, 2'd1, 16'd16384);
      tick(40);

      // Step write on ch2 in the very cycle ch2 issues.
      for (int i = 0; i < 8 && slot[0] != 2; i++) tick(1);
      write_cfg(1'b0, 2'd2, 16'd4096);
      tick(20);
      // Channel 3 exists only on the 4-channel instance.
      write_cfg(1'b0, 2'd3, 16'd5000);
      tick(30);

      enable = 1'b0;
      tick(7);
      enable = 1'b1;
      tick(30);

      repeat (300) begin
         enable = ($urandom_range(0, 9) < 8);
         SET = ($urandom_range(0, 4) == 0);
         set_sel = 1'($urandom_range(0, 1));
         set_channel = 2'($urandom_range(0, 3));
         set_data = 16'($urandom);
         tick(1);
      end
      SET = 1'b0;
      enable = 1'b1;
      tick(20);

      // Asynchronous reset with the pipeline full.
      @(posedge CLK);
      #2 RESET = 1'b0;
      #1;
      check("d0_async_rst_valid", int'(vv[0]), 0, 0);
      check("d1_async_rst_valid", int'(vv[1]), 0, 0);
      tick(3);
      @(posedge CLK);
      #2 RESET = 1'b1;
      tick(60);

      enable = 1'b0;
      tick(LAT + 4);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
